// File: rtl/multi_channel_occupancy_if.sv
// Bundle of push/dequeue/status signals for multi_channel_occupancy.
// The master side drives pushes and the dequeue handshake, and the slave side reports status.
interface multi_channel_occupancy_if #(
  parameter int CHANNELS = 4,
  parameter int CNT_W    = 3,
  parameter int ID_W     = 2
);
  logic [CHANNELS-1:0]       push;
  logic                      deq_ready;
  logic                      deq_valid;
  logic [CHANNELS-1:0]       deq_sel;
  logic [ID_W-1:0]           deq_id;
  logic [CHANNELS-1:0]       empty;
  logic [CHANNELS-1:0]       almost_empty;
  logic [CHANNELS-1:0]       almost_full;
  logic [CHANNELS-1:0]       full;
  logic [CHANNELS*CNT_W-1:0] count;
  logic                      err_clr;
  logic [CHANNELS-1:0]       overflow_err;

  modport master (
    output push, deq_ready, err_clr,
    input  deq_valid, deq_sel, deq_id, empty, almost_empty, almost_full, full, count,
           overflow_err
  );

  modport slave (
    input  push, deq_ready, err_clr,
    output deq_valid, deq_sel, deq_id, empty, almost_empty, almost_full, full, count,
           overflow_err
  );
endinterface

// File: rtl/multi_channel_occupancy.sv
// Per-channel one-hot occupancy chains with a round-robin dequeue selector.
// Optional sticky overflow flags: define MULTI_OCC_OVERFLOW_ERR_EN.
module multi_channel_occupancy #(
  parameter int CHANNELS = 4,
  parameter int DEPTH    = 4,
  parameter int AF_LEVEL = 3,
  parameter int CNT_W    = $clog2(DEPTH + 1),
  parameter int ID_W     = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  multi_channel_occupancy_if.slave bus
);

  logic [DEPTH:0]            chain_r [CHANNELS];
  logic [ID_W-1:0]           rr_ptr_r;
  logic [CHANNELS-1:0]       empty_s;
  logic [CHANNELS-1:0]       almost_empty_s;
  logic [CHANNELS-1:0]       almost_full_s;
  logic [CHANNELS-1:0]       full_s;
  logic [CHANNELS*CNT_W-1:0] count_s;
  logic [ID_W-1:0]           grant_id_s;
  logic                      grant_found_s;
  logic [CHANNELS-1:0]       deq_sel_s;
  logic                      handshake_s;
  logic [CHANNELS-1:0]       pop_s;
  logic [CHANNELS-1:0]       drop_s;

  function automatic logic [CNT_W-1:0] onehot_to_bin(input logic [DEPTH:0] oh);
    logic [CNT_W-1:0] res;
    res = '0;
    for (int j = 0; j <= DEPTH; j++) begin
      res = res | (oh[j] ? CNT_W'(j) : {CNT_W{1'b0}});
    end
    return res;
  endfunction

  // Status decode straight from the chain registers
  always_comb begin
    empty_s        = '0;
    almost_empty_s = '0;
    almost_full_s  = '0;
    full_s         = '0;
    count_s        = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      empty_s[i]                  = chain_r[i][0];
      almost_empty_s[i]           = chain_r[i][1];
      full_s[i]                   = chain_r[i][DEPTH];
      count_s[i*CNT_W +: CNT_W]   = onehot_to_bin(chain_r[i]);
      almost_full_s[i]            = (onehot_to_bin(chain_r[i]) >= CNT_W'(AF_LEVEL));
    end
  end

  // Round-robin grant: first non-empty channel starting at rr_ptr_r
  always_comb begin
    grant_found_s = 1'b0;
    grant_id_s    = '0;
    for (int k = 0; k < CHANNELS; k++) begin
      if (!grant_found_s && !empty_s[ID_W'((int'(rr_ptr_r) + k) % CHANNELS)]) begin
        grant_found_s = 1'b1;
        grant_id_s    = ID_W'((int'(rr_ptr_r) + k) % CHANNELS);
      end else begin
        grant_found_s = grant_found_s;
      end
    end
  end

  // One-hot select, pop and dropped-push vectors
  always_comb begin
    deq_sel_s   = '0;
    handshake_s = grant_found_s & bus.deq_ready;
    for (int j = 0; j < CHANNELS; j++) begin
      deq_sel_s[j] = grant_found_s && (grant_id_s == ID_W'(j));
    end
    pop_s  = handshake_s ? deq_sel_s : {CHANNELS{1'b0}};
    drop_s = bus.push & ~pop_s & full_s;
  end

  // Occupancy chains; a push into a full channel without a pop leaves it unchanged
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < CHANNELS; i++) begin
        chain_r[i] <= {{DEPTH{1'b0}}, 1'b1};
      end
    end else begin
      for (int i = 0; i < CHANNELS; i++) begin
        if (bus.push[i] && !pop_s[i] && !full_s[i]) begin
          chain_r[i] <= {chain_r[i][DEPTH-1:0], 1'b0};
        end else if (pop_s[i] && !bus.push[i]) begin
          chain_r[i] <= {1'b0, chain_r[i][DEPTH:1]};
        end else begin
          chain_r[i] <= chain_r[i];
        end
      end
    end
  end

  // Round-robin pointer moves past the granted channel on each handshake
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr_r <= '0;
    end else if (handshake_s) begin
      if (int'(grant_id_s) == CHANNELS - 1) begin
        rr_ptr_r <= '0;
      end else begin
        rr_ptr_r <= grant_id_s + ID_W'(1);
      end
    end else begin
      rr_ptr_r <= rr_ptr_r;
    end
  end

`ifdef MULTI_OCC_OVERFLOW_ERR_EN
  logic [CHANNELS-1:0] overflow_err_r;

  // Sticky overflow flags; a new drop beats a same-cycle clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow_err_r <= '0;
    end else begin
      overflow_err_r <= drop_s | (bus.err_clr ? {CHANNELS{1'b0}} : overflow_err_r);
    end
  end

`ifndef SYNTHESIS
  // Simulation report of a dropped push
  always_ff @(posedge clk) begin
    if (rst_n && (|drop_s)) begin
      $error("multi_channel_occupancy: push dropped on full channel(s) %b", drop_s);
    end
  end
`endif

  assign bus.overflow_err = overflow_err_r;
`else
  logic unused_err_clr_s;
  assign unused_err_clr_s = bus.err_clr ^ (|drop_s);
  assign bus.overflow_err = '0;
`endif

  assign bus.empty        = empty_s;
  assign bus.almost_empty = almost_empty_s;
  assign bus.almost_full  = almost_full_s;
  assign bus.full         = full_s;
  assign bus.count        = count_s;
  assign bus.deq_valid    = grant_found_s;
  assign bus.deq_sel      = deq_sel_s;
  assign bus.deq_id       = grant_id_s;

endmodule
